// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with a block-RAM read-address
// lookahead and a programmable update strobe.
//
// Optional feature macro: VGA_FRAME_COUNTER_EN. When it is defined, frame_count
// counts frame starts since reset. When it is undefined, frame_count is tied to 0.
//
// Interface contract: there is no handshake. Every output is a registered
// level or strobe. Each one is aligned to the hcount/vcount that it describes.
// The exception is re/raddr, which describe the pixel shown on the NEXT cycle.
// A synchronous RAM with one cycle of latency can use them directly.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BLOCK_W  = 20,
  parameter int BLOCK_H  = 20,
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 5,
  parameter int DUR_W    = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DUR_W-1:0]             next_duration,
  output logic [9:0]                   hcount,
  output logic [9:0]                   vcount,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         active,
  output logic                         frame_start,
  output logic                         re,
  output logic [ROW_BITS+COL_BITS-1:0] raddr,
  output logic                         updateoutput,
  output logic [15:0]                  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BX_W    = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int BY_W    = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
  localparam int AW      = ROW_BITS + COL_BITS;

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BX_W-1:0] BX_LAST = BX_W'(BLOCK_W - 1);
  localparam logic [BY_W-1:0] BY_LAST = BY_W'(BLOCK_H - 1);

  // started is low only during the first edge after reset. On that edge the
  // raster loads (0,0) instead of advancing.
  logic                started;
  logic [9:0]          h_nxt, v_nxt;
  logic                act_nxt, hs_nxt, vs_nxt, fs_nxt;

  // The lookahead position runs one pixel ahead of the displayed raster.
  // Block sub-counters are kept for that lookahead pixel, so no divider is needed.
  logic [9:0]          la_h, la_v, la_h_nxt, la_v_nxt;
  logic [BX_W-1:0]     la_bx, la_bx_nxt;
  logic [BY_W-1:0]     la_by, la_by_nxt;
  logic [COL_BITS-1:0] la_col, la_col_nxt;
  logic [ROW_BITS-1:0] la_row, la_row_nxt;
  logic                la_line_wrap, la_frame_wrap;
  logic                re_nxt;
  logic [AW-1:0]       raddr_nxt;

  // dur holds the strobe period that was latched at the last strobe.
  // cnt counts the active pixels shown since that strobe.
  logic [DUR_W-1:0]    dur, dur_nxt, dur_in, cnt, cnt_nxt;
  logic [DUR_W:0]      cnt_inc;
  logic                upd_nxt;

  // Next displayed raster position and the sync/active levels that belong to it
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (started) begin
      if (hcount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
        h_nxt = hcount + 10'd1;
        v_nxt = vcount;
      end
    end
    act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt  = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
    vs_nxt  = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
    fs_nxt  = (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

  // Advance the lookahead pixel and its block sub-counters, then decide the RAM read
  always_comb begin
    la_line_wrap  = (la_h == H_LAST);
    la_frame_wrap = la_line_wrap && (la_v == V_LAST);
    la_h_nxt      = la_h;
    la_v_nxt      = la_v;
    la_bx_nxt     = la_bx;
    la_by_nxt     = la_by;
    la_col_nxt    = la_col;
    la_row_nxt    = la_row;
    if (la_line_wrap) begin
      la_h_nxt   = '0;
      la_bx_nxt  = '0;
      la_col_nxt = '0;
      if (la_frame_wrap) begin
        la_v_nxt   = '0;
        la_by_nxt  = '0;
        la_row_nxt = '0;
      end else begin
        la_v_nxt = la_v + 10'd1;
        if (la_by == BY_LAST) begin
          la_by_nxt  = '0;
          la_row_nxt = la_row + ROW_BITS'(1);
        end else begin
          la_by_nxt = la_by + BY_W'(1);
        end
      end
    end else begin
      la_h_nxt = la_h + 10'd1;
      if (la_bx == BX_LAST) begin
        la_bx_nxt  = '0;
        la_col_nxt = la_col + COL_BITS'(1);
      end else begin
        la_bx_nxt = la_bx + BX_W'(1);
      end
    end
    // The first pixel of a line always has bx==0, so line starts are covered too.
    re_nxt    = (la_h_nxt < H_ACT) && (la_v_nxt < V_ACT) && (la_bx_nxt == '0);
    raddr_nxt = re_nxt ? {la_row_nxt, la_col_nxt} : raddr;
  end

  // Update strobe: held high in blanking, and pulsed every dur active pixels
  // starting at each line segment
  always_comb begin
    dur_in  = (next_duration == '0) ? DUR_W'(1) : next_duration;
    cnt_inc = {1'b0, cnt} + (DUR_W+1)'(1);
    upd_nxt = 1'b1;
    dur_nxt = dur;
    cnt_nxt = cnt;
    if (act_nxt) begin
      if ((h_nxt == 10'd0) || (cnt_inc >= {1'b0, dur})) begin
        upd_nxt = 1'b1;
        dur_nxt = dur_in;
        cnt_nxt = '0;
      end else begin
        upd_nxt = 1'b0;
        cnt_nxt = cnt_inc[DUR_W-1:0];
      end
    end
  end

  // Register the raster, the lookahead, the strobe state and all outputs together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started      <= 1'b0;
      hcount       <= '0;
      vcount       <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      active       <= 1'b0;
      frame_start  <= 1'b0;
      la_h         <= '0;
      la_v         <= '0;
      la_bx        <= '0;
      la_by        <= '0;
      la_col       <= '0;
      la_row       <= '0;
      re           <= 1'b0;
      raddr        <= '0;
      updateoutput <= 1'b1;
      dur          <= DUR_W'(1);
      cnt          <= '0;
    end else begin
      started      <= 1'b1;
      hcount       <= h_nxt;
      vcount       <= v_nxt;
      hsync        <= hs_nxt;
      vsync        <= vs_nxt;
      active       <= act_nxt;
      frame_start  <= fs_nxt;
      la_h         <= la_h_nxt;
      la_v         <= la_v_nxt;
      la_bx        <= la_bx_nxt;
      la_by        <= la_by_nxt;
      la_col       <= la_col_nxt;
      la_row       <= la_row_nxt;
      re           <= re_nxt;
      raddr        <= raddr_nxt;
      updateoutput <= upd_nxt;
      dur          <= dur_nxt;
      cnt          <= cnt_nxt;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_cnt;

  // Count frames; the count steps on the same edge that raises frame_start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (fs_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_count = frame_cnt;
`else
  assign frame_count = 16'd0;
`endif

endmodule
